axi4s_demux_tid: RTL
====================

Name: axi4s_demux_tid

Overview:
- Downstream neighbour of the round-robin AXI4-S mux.
- Consumes the merged stream (tid, tdata, tlast) and routes each packet to output stream number tid.
- Registered output stage, full-throughput handshake.
- Packet-aware: the destination is locked on the first beat and held until tlast. Packets with an out-of-range tid are discarded.

Parameters:
- nr_of_streams_p, -1 (must be set, >=2): number of output streams.
- tdata_width_p, -1 (must be set, >=1): tdata width in bytes; the bus is tdata_width_p*8 bits.
- tid_bit_width_p, $clog2(nr_of_streams_p): width of tid.

Ports:
- clk  input  1  clock; one clock domain.
- rst_n  input  1  asynchronous active-low reset.
- axi4s_i_tready  output  1  input-side ready.
- axi4s_i_tvalid  input  1  input valid.
- axi4s_i_tlast  input  1  input last beat of packet.
- axi4s_i_tid  input  tid_bit_width_p  destination stream index.
- axi4s_i_tdata  input  tdata_width_p*8  input data.
- axi4s_o_tready  input  nr_of_streams_p  per-output ready.
- axi4s_o_tvalid  output  nr_of_streams_p  per-output valid.
- axi4s_o_tlast  output  nr_of_streams_p  per-output last.
- axi4s_o_tdata  output  [nr_of_streams_p][tdata_width_p*8]  per-output data.
- drop_pulse  output  1  one-cycle pulse on the tlast beat of each discarded packet.

Behaviour:
- Reset (async assert, sync release): all axi4s_o_tvalid/tlast/tdata = 0, drop_pulse = 0, state = IDLE, dest register = 0.
- axi4s_i_tready is combinational:
  - IDLE and ROUTE: ready = !axi4s_o_tvalid[dest_sel] || axi4s_o_tready[dest_sel].
  - DROP: ready = 1.
  - dest_sel = axi4s_i_tid in IDLE, the locked dest register in ROUTE.
- A beat is accepted when axi4s_i_tvalid && axi4s_i_tready.
- An accepted routed beat appears on output dest_sel on the next cycle: tvalid[dest]=1, tdata/tlast captured. Latency is 1 clk.
- Output register d clears tvalid when it handshakes (tvalid[d] && tready[d]) and no new beat loads it that cycle.
- Back-to-back beats into the same output sustain 1 beat/clk while tready is held high.
- Only one output register loads per cycle; other outputs hold their data stable while their tvalid=1 (AXI-S stability rule).
- State machine:
  - IDLE, accepted beat, tid < nr_of_streams_p, tlast=0 -> ROUTE; dest register <= tid.
  - IDLE, accepted beat, tid < nr_of_streams_p, tlast=1 -> stays IDLE (single-beat packet).
  - IDLE, tvalid && tid >= nr_of_streams_p -> ready=1, beat discarded. tlast=1: drop_pulse next cycle, stay IDLE. tlast=0: -> DROP.
  - ROUTE: tid is ignored; all beats go to the locked dest. Accepted beat with tlast=1 -> IDLE.
  - DROP: all beats accepted and discarded; tlast=1 beat -> IDLE, drop_pulse=1 next cycle.
- tid change mid-packet: ignored; the packet stays on the locked destination.
- Outputs not addressed by the current beat are never stalled by, and never stall, the addressed output. Head-of-line blocking applies only through the single input.
- Input tvalid low mid-packet: state held; no timeout.
- tid out-of-range check is needed only when nr_of_streams_p is not a power of two; otherwise DROP is unreachable.
- Reset mid-packet: outputs cleared immediately. Any partial packet is lost and the next accepted beat is treated as a packet start.

Optional Feature:
- Macro AXI4S_DEMUX_STATS_EN.
- When defined, adds these outputs:
  - pkt_cnt [nr_of_streams_p][32]: per-output packet counters, incremented when an output handshakes a beat with tlast=1.
  - drop_cnt [32]: incremented with each drop_pulse.
  - Counters wrap modulo 2^32 and reset to 0.
  - stats_clr input (1): synchronously clears all counters; a clear has priority over a same-cycle increment.
- When undefined: no counter ports or logic. Routing behaviour is identical in both cases.

Test Plan:
- N=4, W=4. Send a 3-beat packet, tid=2, data 0x11/0x22/0x33, all tready=1 -> output 2 shows the same data one cycle after each input beat, tlast on 0x33; outputs 0, 1, 3 keep tvalid=0.
- tid=1, 4-beat packet; axi4s_o_tready[1] low for 3 cycles after beat 2 -> axi4s_i_tready=0 while output 1 holds beat 2 stable; no loss or duplication; throughput resumes at 1 beat/clk.
- 2-beat packet with tid=0 then tid=3 on beat 2 -> both beats emerge on output 0; output 3 idle.
- N=3, 2-beat packet with tid=3 -> ready=1 for both beats, no output tvalid, drop_pulse high for exactly 1 cycle after the tlast beat; the next tid=0 packet routes normally.
- Assert rst_n=0 mid-packet (beat 2 of 4, tid=1) -> all tvalid=0 immediately. After release, a new tid=2 packet routes to output 2.
- With AXI4S_DEMUX_STATS_EN: 5 packets to output 0 and 2 dropped -> pkt_cnt[0]=5, drop_cnt=2. stats_clr pulse -> all counters 0.

Source files
------------

// File: rtl/axi4s_demux_tid_if.sv
// AXI4-Stream bundle between the merged input stream and the per-tid outputs
// of axi4s_demux_tid.
//   axi4s_i_*  : merged input stream (tvalid/tready/tlast/tid/tdata)
//   axi4s_o_*  : one stream per destination, packed [stream][bit]
// Modports:
//   slave  : the demux view (consumes axi4s_i_*, produces axi4s_o_*)
//   master : the surrounding fabric (drives axi4s_i_*, sinks axi4s_o_*)
interface axi4s_demux_tid_if #(
    parameter int nr_of_streams_p = -1,
    parameter int tdata_width_p   = -1,
    parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
);
    logic                                               axi4s_i_tready;
    logic                                               axi4s_i_tvalid;
    logic                                               axi4s_i_tlast;
    logic [tid_bit_width_p-1:0]                         axi4s_i_tid;
    logic [tdata_width_p*8-1:0]                         axi4s_i_tdata;
    logic [nr_of_streams_p-1:0]                         axi4s_o_tready;
    logic [nr_of_streams_p-1:0]                         axi4s_o_tvalid;
    logic [nr_of_streams_p-1:0]                         axi4s_o_tlast;
    logic [nr_of_streams_p-1:0][tdata_width_p*8-1:0]    axi4s_o_tdata;

    modport slave (
        output axi4s_i_tready,
        input  axi4s_i_tvalid, axi4s_i_tlast, axi4s_i_tid, axi4s_i_tdata,
        input  axi4s_o_tready,
        output axi4s_o_tvalid, axi4s_o_tlast, axi4s_o_tdata
    );

    modport master (
        input  axi4s_i_tready,
        output axi4s_i_tvalid, axi4s_i_tlast, axi4s_i_tid, axi4s_i_tdata,
        output axi4s_o_tready,
        input  axi4s_o_tvalid, axi4s_o_tlast, axi4s_o_tdata
    );
endinterface

// File: rtl/axi4s_demux_tid.sv
// axi4s_demux_tid: routes each packet of a merged AXI4-Stream to output
// stream number tid. The destination is locked on the first beat and held
// until tlast; packets whose tid has no output are swallowed and reported
// with a one-cycle drop_pulse. Each output is a single register stage, so an
// accepted beat shows up one clock later and a ready output sustains 1 beat/clk.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   s             axi4s_demux_tid_if.slave (input stream + per-output streams)
//   drop_pulse    high for one cycle after the tlast beat of a dropped packet
// Optional (macro AXI4S_DEMUX_STATS_EN):
//   stats_clr     synchronous clear of all counters (wins over an increment)
//   pkt_cnt       per-output count of tlast handshakes, wraps at 2^32
//   drop_cnt      count of drop_pulse cycles, wraps at 2^32

// One output register stage. A load always wins; otherwise the stage empties
// on its own handshake. Data only changes on a load, so it is stable while
// tvalid is held.
module axi4s_demux_tid_lane #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] tdata_in,
    input  logic          tlast_in,
    input  logic          tready,
    output logic          tvalid,
    output logic          tlast,
    output logic [DW-1:0] tdata
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= '0;
        end else if (load) begin
            tvalid <= 1'b1;
            tlast  <= tlast_in;
            tdata  <= tdata_in;
        end else if (tvalid && tready) begin
            tvalid <= 1'b0;
        end
    end
endmodule

module axi4s_demux_tid #(
    parameter int nr_of_streams_p = -1,
    parameter int tdata_width_p   = -1,
    parameter int tid_bit_width_p = $clog2(nr_of_streams_p)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    axi4s_demux_tid_if.slave                  s,
    output logic                              drop_pulse
`ifdef AXI4S_DEMUX_STATS_EN
    ,
    input  logic                              stats_clr,
    output logic [nr_of_streams_p-1:0][31:0]  pkt_cnt,
    output logic [31:0]                       drop_cnt
`endif
);
    localparam int DW = tdata_width_p * 8;
    // With a power-of-two stream count every tid has an output and DROP
    // can never be entered.
    localparam bit TID_FULL = ((1 << tid_bit_width_p) == nr_of_streams_p);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t                     state_q, state_d;
    logic [tid_bit_width_p-1:0] dest_q, dest_d, dest_sel;
    logic                       tid_ok, sel_busy, ready, drop_d, route_acc;
    logic [nr_of_streams_p-1:0] load;

    assign tid_ok   = TID_FULL || (32'(s.axi4s_i_tid) < 32'(nr_of_streams_p));
    // Packet start uses the live tid; the rest of the packet the locked one.
    assign dest_sel = (state_q == ROUTE) ? dest_q : s.axi4s_i_tid;
    assign s.axi4s_i_tready = ready;

    // Selected output can't take a beat: full and not draining this cycle.
    always_comb begin
        sel_busy = 1'b0;
        for (int i = 0; i < nr_of_streams_p; i++) begin
            if (dest_sel == tid_bit_width_p'(i))
                sel_busy = s.axi4s_o_tvalid[i] && !s.axi4s_o_tready[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        ready     = !sel_busy;
        drop_d    = 1'b0;
        route_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!tid_ok) begin
                    ready = 1'b1;
                    if (s.axi4s_i_tvalid) begin
                        if (s.axi4s_i_tlast) drop_d  = 1'b1;
                        else                 state_d = DROP;
                    end
                end else if (s.axi4s_i_tvalid && ready) begin
                    route_acc = 1'b1;
                    if (!s.axi4s_i_tlast) begin
                        state_d = ROUTE;
                        dest_d  = s.axi4s_i_tid;
                    end
                end
            end
            ROUTE: begin
                if (s.axi4s_i_tvalid && ready) begin
                    route_acc = 1'b1;
                    if (s.axi4s_i_tlast) state_d = IDLE;
                end
            end
            DROP: begin
                ready = 1'b1;
                if (s.axi4s_i_tvalid && s.axi4s_i_tlast) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load = '0;
        for (int i = 0; i < nr_of_streams_p; i++)
            load[i] = route_acc && (dest_sel == tid_bit_width_p'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            dest_q     <= '0;
            drop_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            drop_pulse <= drop_d;
        end
    end

    for (genvar g = 0; g < nr_of_streams_p; g++) begin : g_lane
        axi4s_demux_tid_lane #(.DW(DW)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load[g]),
            .tdata_in (s.axi4s_i_tdata),
            .tlast_in (s.axi4s_i_tlast),
            .tready   (s.axi4s_o_tready[g]),
            .tvalid   (s.axi4s_o_tvalid[g]),
            .tlast    (s.axi4s_o_tlast[g]),
            .tdata    (s.axi4s_o_tdata[g])
        );
    end

`ifdef AXI4S_DEMUX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else if (stats_clr) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            for (int i = 0; i < nr_of_streams_p; i++) begin
                if (s.axi4s_o_tvalid[i] && s.axi4s_o_tready[i] && s.axi4s_o_tlast[i])
                    pkt_cnt[i] <= pkt_cnt[i] + 32'd1;
            end
            if (drop_pulse) drop_cnt <= drop_cnt + 32'd1;
        end
    end
`endif
endmodule
